// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by the IF/ID register and decode.
package fetch_pkg;

    localparam int ADDR_W = 13;
    localparam int INST_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam addr_t      RESET_PC = 13'h0000;
    localparam inst_t      NOP_INST = 16'h0000;
    localparam logic [3:0] HALT_OP  = 4'hF;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input inst_t inst);
        return inst[15:12] == HALT_OP;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: pipeline control in, ROM port, and the IF/ID-facing outputs.
interface instruction_fetch_unit_if;
    import fetch_pkg::*;

    logic  stall;
    logic  redirect_valid;
    addr_t redirect_addr;
    addr_t rom_addr;
    inst_t rom_data;
    inst_t inst_out;
    addr_t pc_out;
    logic  inst_valid;
    logic  halted;

    // fetch unit side
    modport master (
        input  stall, redirect_valid, redirect_addr, rom_data,
        output rom_addr, inst_out, pc_out, inst_valid, halted
    );

    // pipeline / ROM side
    modport slave (
        output stall, redirect_valid, redirect_addr, rom_data,
        input  rom_addr, inst_out, pc_out, inst_valid, halted
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch sequencing in front of a synchronous instruction ROM.
//
//   state  | meaning
//   RUN    | fetching one instruction per cycle (or holding under stall)
//   HALTED | HALT was emitted; outputs NOP until a redirect restarts fetch
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input logic                       clock,
    input logic                       reset_n,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t state_q, state_d;
    addr_t        fetch_pc_q, fetch_pc_d;
    addr_t        pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic         inst_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;

        // a redirect kills whatever ROM data is in flight this cycle
        inst_valid     = pend_valid_q & ~bus.redirect_valid & (state_q == RUN);
        bus.inst_valid = inst_valid;
        bus.inst_out   = inst_valid ? bus.rom_data : NOP_INST;
        bus.pc_out     = pend_pc_q;
        bus.halted     = (state_q == HALTED);

        // re-reading pend_pc keeps rom_data stable while nothing advances
        if (bus.redirect_valid)
            bus.rom_addr = bus.redirect_addr;
        else if (bus.stall || state_q == HALTED)
            bus.rom_addr = pend_pc_q;
        else
            bus.rom_addr = fetch_pc_q;

        if (bus.redirect_valid) begin
            state_d      = RUN;
            pend_pc_d    = bus.redirect_addr;
            pend_valid_d = 1'b1;
            fetch_pc_d   = bus.redirect_addr + addr_t'(1);
        end else if (state_q == RUN && !bus.stall) begin
            if (inst_valid && is_halt(bus.rom_data)) begin
                state_d      = HALTED;
                pend_valid_d = 1'b0;
            end else begin
                pend_pc_d    = fetch_pc_q;
                pend_valid_d = 1'b1;
                fetch_pc_d   = fetch_pc_q + addr_t'(1);
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the pipeline: owns the 13-bit program counter, drives the instruction ROM address, and presents each fetched 16-bit instruction with its address to the IF/ID register, which samples it on the falling edge of `clock`. Handles back-pressure (stall), control-flow redirects from later stages, and the halt instruction.

## Interface
- `ADDR_W`, 13, instruction address width
- `INST_W`, 16, instruction width
- `RESET_PC`, 13'h0000, first fetch address after reset
- `NOP_INST`, 16'h0000, bubble instruction
- `HALT_OP`, 4'hF, opcode in `inst[15:12]` that stops fetch

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold current output, fetch nothing new
- `redirect_valid`  in  1  jump/branch taken; has priority over `stall`
- `redirect_addr`  in  ADDR_W  redirect target
- `rom_addr`  out  ADDR_W  address to synchronous ROM (captured at rising edge, data valid next cycle)
- `rom_data`  in  INST_W  ROM read data
- `inst_out`  out  INST_W  instruction to IF/ID
- `pc_out`  out  ADDR_W  address of `inst_out`
- `inst_valid`  out  1  `inst_out` is a real instruction
- `halted`  out  1  fetch stopped by HALT

## Operation
- Registers: `fetch_pc` (next address), `pend_pc` (address whose data is on `rom_data`), `pend_valid`, `state` ∈ {RUN, HALTED}.
- `rom_addr` (combinational): `redirect_valid` → `redirect_addr`; else `stall` or HALTED → `pend_pc`; else `fetch_pc`.
- Outputs (combinational): `inst_valid = pend_valid & ~redirect_valid & (state==RUN)`; `inst_out = inst_valid ? rom_data : NOP_INST`; `pc_out = pend_pc`; `halted = (state==HALTED)`.
- RUN, `redirect_valid`: `pend_pc <= redirect_addr`, `pend_valid <= 1`, `fetch_pc <= redirect_addr+1`. Current output killed (wrong path).
- RUN, `stall` (no redirect): all registers hold; ROM re-reads `pend_pc`, so output is stable.
- RUN, advance: `pend_pc <= fetch_pc`, `pend_valid <= 1`, `fetch_pc <= fetch_pc+1`.
- RUN, advancing with `inst_valid` and `inst_out[15:12]==HALT_OP`: the HALT itself is emitted this cycle; next state HALTED, `pend_valid <= 0`, `fetch_pc` holds.
- HALTED: outputs NOP, `inst_valid=0`; `stall` ignored; only `redirect_valid` leaves, performing the redirect update and returning to RUN.
- Address arithmetic modulo 2^ADDR_W: 13'h1FFF + 1 → 13'h0000, no flag.

## Timing
- Reset (async assert): `fetch_pc=RESET_PC`, `pend_pc=RESET_PC`, `pend_valid=0`, state RUN. During reset: `rom_addr=RESET_PC`, `inst_out=NOP_INST`, `pc_out=RESET_PC`, `inst_valid=0`, `halted=0`.
- First edge after release: ROM captures RESET_PC; one cycle later `inst_valid=1`, `pc_out=RESET_PC`. Fetch latency 1 cycle; throughput 1 instruction/cycle.
- Redirect: target instruction valid the cycle after the redirect edge; exactly one killed slot (the cycle `redirect_valid` is high).
- Stall and redirect together: redirect wins.
- Reset mid-stall or mid-HALTED: returns immediately to reset values.
- `redirect_valid` → `inst_valid`/`inst_out` and `stall` → `rom_addr` are combinational paths; drivers must be registered or settle before the falling edge.

## Structure
- Package `fetch_pkg`: `ADDR_W`, `INST_W`, `NOP_INST`, `HALT_OP`, `fetch_state_t` enum {RUN, HALTED}, `inst_t`/`addr_t` typedefs; shared with the IF/ID register and decode.
- No sub-module; ROM stays outside. One always_ff for state, one always_comb for `rom_addr`/outputs.

## Test plan
- Reset release, ROM[0..3]=16'h1111,2222,3333,4444 → outputs 1111@0,2222@1,3333@2,4444@3 on consecutive cycles, `inst_valid=1` from cycle 1.
- Stall 3 cycles while `pc_out=2` → `inst_out=3333`, `pc_out=2` held 4 cycles, then 4444@3.
- Redirect to 13'h0100 while `pc_out=1` → that cycle `inst_valid=0`, next cycle `pc_out=0100` with ROM[0100]; redirect+stall same cycle → redirect taken.
- ROM[5]=16'hF000 → HALT emitted at `pc_out=5`, then `halted=1`, `inst_valid=0` indefinitely; redirect to 0 → fetch resumes at 0, `halted=0`.
- Redirect to 13'h1FFF → 1FFF followed by 0000 (wrap).
- Assert `reset_n` low mid-stream and mid-HALTED → outputs return to reset values asynchronously; restart from RESET_PC.
